// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-step shift-add multiplier / restoring divider owning the HI/LO pair
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   src_rs,
  input  logic [XLEN-1:0]   src_rt,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              dbz,
  output logic [2*XLEN-1:0] hilo_q
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [XLEN-1:0] a, b, hi, lo;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic is_div, neg_q, neg_r;
  logic idle_ok, go, rs_neg, rt_neg, ge, dbz_now;
  logic [XLEN-1:0] abs_rs, abs_rt, diff, quo, rem, fix_hi, fix_lo;
  logic [XLEN:0] msum, rem_sh;
  assign idle_ok = state == IDLE && start && !flush;
  assign go      = idle_ok && !op[2];
  assign rs_neg  = !op[0] && src_rs[XLEN-1];
  assign rt_neg  = !op[0] && src_rt[XLEN-1];
  assign abs_rs  = rs_neg ? -src_rs : src_rs;
  assign abs_rt  = rt_neg ? -src_rt : src_rt;
  // Multiply keeps the multiplier in acc's low half and shifts the sum in from the top
  assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? a : {XLEN{1'b0}}};
  assign rem_sh  = acc[2*XLEN-1:XLEN-1];
  assign ge      = rem_sh >= {1'b0, b};
  assign diff    = rem_sh[XLEN-1:0] - b;
  assign acc_nx  = is_div ? {ge ? diff : rem_sh[XLEN-1:0], acc[XLEN-2:0], ge}
                          : {msum, acc[XLEN-1:1]};
  assign prod    = neg_q ? -acc : acc;
  assign quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem     = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign dbz_now = is_div && b == '0;
  // Negating the stored magnitude recovers the raw dividend for the divide-by-zero HI value
  assign fix_hi  = dbz_now ? (neg_r ? -a : a) : is_div ? rem : prod[2*XLEN-1:XLEN];
  assign fix_lo  = dbz_now ? {XLEN{1'b1}} : is_div ? quo : prod[XLEN-1:0];
  assign busy    = state != IDLE;
  assign hilo_q  = {hi, lo};
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = go ? CALC : IDLE;
    else if (flush) state_nx = IDLE;
    else if (state == CALC) state_nx = cnt == 6'd31 ? FIX : CALC;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk_cpu or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      done <= state == FIX && !flush;
      dbz  <= state == FIX && !flush && dbz_now;
      if (go) begin
        a      <= abs_rs;
        b      <= abs_rt;
        acc    <= {{XLEN{1'b0}}, op[1] ? abs_rs : abs_rt};
        is_div <= op[1];
        neg_q  <= rs_neg ^ rt_neg;
        neg_r  <= rs_neg;
        cnt    <= '0;
      end
      if (idle_ok && op == 3'd4) hi <= src_rs;
      if (idle_ok && op == 3'd5) lo <= src_rs;
      if (state == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 6'd1;
      end
      if (state == FIX && !flush) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end
endmodule
